// File: rtl/riscv_run_ctrl.sv
// Bring-up run controller for a RISC-V core. It holds the core in reset, lets it run
// until the PC parks on a halt address, then checks one register through the debug port.
module riscv_run_ctrl #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 2,
  parameter int HALT_STABLE  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      max_cycles,
  input  logic [XLEN-1:0]       halt_pc,
  input  logic [REG_ADDR_W-1:0] check_reg,
  input  logic [XLEN-1:0]       expect_val,
  output logic                  core_reset,
  input  logic [XLEN-1:0]       core_pc,
  output logic [REG_ADDR_W-1:0] dbg_raddr,
  input  logic [XLEN-1:0]       dbg_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [XLEN-1:0]       result_val
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int STW = $clog2(HALT_STABLE + 1);
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  logic [2:0]            state;
  logic [RCW-1:0]        rst_cnt;
  logic [STW-1:0]        stable_cnt;
  logic [CNT_W-1:0]      max_q;
  logic [XLEN-1:0]       halt_q;
  logic [XLEN-1:0]       expect_q;
  logic [REG_ADDR_W-1:0] reg_q;

  logic [CNT_W-1:0] cnt_next;
  logic [STW-1:0]   stab_next;
  logic             halt_hit;
  logic             budget_end;

  always_comb begin
    cnt_next   = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
    stab_next  = (core_pc == halt_q) ? stable_cnt + 1'b1 : '0;
    halt_hit   = (stab_next == STW'(HALT_STABLE));
    // A zero budget still gets one RUN cycle before the timeout is declared.
    budget_end = (cnt_next == max_q) || (max_q == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      stable_cnt  <= '0;
      max_q       <= '0;
      halt_q      <= '0;
      expect_q    <= '0;
      reg_q       <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      result_val  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            max_q       <= max_cycles;
            halt_q      <= halt_pc;
            reg_q       <= check_reg;
            expect_q    <= expect_val;
            cycle_count <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            stable_cnt  <= '0;
            rst_cnt     <= RCW'(RESET_CYCLES - 1);
            state       <= S_RESET;
          end
        end
        S_RESET: begin
          if (rst_cnt == '0) state <= S_RUN;
          else rst_cnt <= rst_cnt - 1'b1;
        end
        S_RUN: begin
          cycle_count <= cnt_next;
          stable_cnt  <= stab_next;
          // Halt takes priority over a budget that runs out on the same cycle.
          if (halt_hit) begin
            state <= S_CHECK;
          end else if (budget_end) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_CHECK: begin
          result_val <= dbg_rdata;
          pass       <= (dbg_rdata == expect_q);
          state      <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so the core reset asserts as soon as the async reset lands.
  assign core_reset = (state == S_IDLE) || (state == S_RESET);
  assign busy       = (state == S_RESET) || (state == S_RUN) || (state == S_CHECK);
  assign done       = (state == S_DONE);
  assign dbg_raddr  = reg_q;

endmodule

// File: doc/riscv_run_ctrl.md
Name: riscv_run_ctrl

Overview:
- Synthesizable run controller that wraps a RISC-V core (single-cycle or pipelined) for self-checking bring-up on silicon or FPGA.
- Sequence per run:
  - Holds the core in reset for a programmable number of cycles, then releases it.
  - Counts execution cycles and detects a halt (PC parked at a halt address).
  - Reads one architectural register through the core's debug read port and compares it to an expected value.
  - Reports pass, fail or timeout.
- Sits between the core and a host or top-level status logic.

Parameters:
- XLEN, 32, data/PC width.
- REG_ADDR_W, 5, register-file address width (5 = RV32I, 4 = RV32E).
- CNT_W, 16, cycle counter width.
- RESET_CYCLES, 2, cycles the core reset is held after start (>=1).
- HALT_STABLE, 2, consecutive cycles with core_pc == halt_pc needed to declare halt (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a run; accepted only in IDLE or DONE.
- max_cycles  input  CNT_W  run-cycle budget, sampled at start; 0 = timeout on first RUN cycle.
- halt_pc  input  XLEN  halt address, sampled at start.
- check_reg  input  REG_ADDR_W  register index to check, sampled at start.
- expect_val  input  XLEN  expected register value, sampled at start.
- core_reset  output  1  active-high reset to core.
- core_pc  input  XLEN  core program counter.
- dbg_raddr  output  REG_ADDR_W  debug read address to core register file.
- dbg_rdata  input  XLEN  debug read data, combinational from dbg_raddr.
- busy  output  1  high in RESET, RUN, CHECK.
- done  output  1  high in DONE.
- pass  output  1  valid when done: register matched, no timeout.
- timeout  output  1  valid when done: budget exhausted before halt.
- cycle_count  output  CNT_W  RUN cycles elapsed; held in DONE.
- result_val  output  XLEN  captured register value; held in DONE.

Behaviour:
- Reset (reset = 0, async):
  - State IDLE; core_reset = 1.
  - busy, done, pass, timeout = 0; cycle_count = 0; result_val = 0.
  - dbg_raddr = 0; all captured config registers cleared.
- States: IDLE, RESET, RUN, CHECK, DONE.
- IDLE:
  - core_reset = 1.
  - start -> capture max_cycles, halt_pc, check_reg and expect_val; clear cycle_count, pass and timeout; go to RESET.
- RESET:
  - core_reset = 1 for exactly RESET_CYCLES cycles (internal down-counter), then go to RUN.
  - The core's first released cycle is the first RUN cycle.
- RUN, per cycle:
  - core_reset = 0; cycle_count increments (saturating at all-ones).
  - Stable counter: +1 if core_pc == halt_pc, else cleared to 0.
  - Halt: stable counter reaches HALT_STABLE -> go to CHECK.
  - Timeout: otherwise, cycle_count == max_cycles -> timeout = 1, go to DONE.
  - Halt and budget end in the same cycle: halt wins (CHECK, timeout = 0).
- CHECK (exactly 1 cycle):
  - core_reset stays 0 (core spins on halt loop); dbg_raddr = captured check_reg.
  - At cycle end: result_val <= dbg_rdata; pass <= (dbg_rdata == expect_val); go to DONE.
- DONE:
  - done = 1; outputs frozen; core_reset = 0; dbg_raddr holds.
  - start -> re-captures config and restarts at RESET, clearing done, pass, timeout and cycle_count on that edge.
- start is ignored in RESET, RUN and CHECK.
- dbg_raddr equals the captured check_reg from start onward. The one-cycle CHECK state gives the register file a full cycle to settle.
- Latency:
  - start -> first RUN cycle = RESET_CYCLES + 1.
  - halt detected -> done = 2 cycles (CHECK, then DONE).
- Async reset asserted mid-run: everything returns to IDLE immediately; core_reset asserts asynchronously.

Test Plan:
- RESET_CYCLES = 2, HALT_STABLE = 2, core program computes x3 = 5 then jumps to self at 0x0000_0010; start with halt_pc = 0x10, check_reg = 3, expect_val = 5, max_cycles = 100.
  - core_reset high for exactly 2 cycles after start.
  - done = 1, pass = 1, timeout = 0, result_val = 5.
  - cycle_count = cycles from release to 2nd consecutive PC = 0x10.
- Same program, expect_val = 6 -> done = 1, pass = 0, timeout = 0, result_val = 5.
- halt_pc = 0xFFFF_FFF0 (never reached), max_cycles = 20 -> done after 20 RUN cycles, timeout = 1, pass = 0, cycle_count = 20.
- max_cycles set so the budget ends in the same cycle the halt is detected -> CHECK taken, timeout = 0, pass reflects the compare.
- PC touches halt_pc for 1 cycle then leaves (HALT_STABLE = 2) -> no halt, run continues.
- Pulse start during RUN -> ignored; drop reset low mid-RUN -> IDLE, core_reset = 1, all flags 0.
- Second start from DONE -> flags cleared on that edge, new run completes correctly.
